debug_probe_viewer: RTL

Debug display controller between the MIPS core's probe signals and the eight-digit hex display decoders. It debounces two push-buttons that step a probe index forward or backward with wrap-around. It optionally freezes a snapshot of all probes and presents one registered 32-bit word plus the current index. Hex decoding stays downstream; probe packing (zero-extension of narrow signals) stays upstream.

---
 rtl/debug_probe_pkg.sv | 25 ++
 rtl/debug_probe_viewer_input_debounce.sv | 65 ++++++
 rtl/debug_probe_viewer.sv | 103 ++++++++++
 3 files changed

// File: rtl/debug_probe_pkg.sv
// Shared constants for the MIPS probe viewer: probe count, index width and
// the fixed meaning of each probe slot on probe_bus.
package debug_probe_pkg;

  localparam int NUM_PROBES_DEF = 14;
  localparam int SEL_W          = 4;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t PRB_PC         = 4'd0;
  localparam sel_t PRB_ALU_RESULT = 4'd1;
  localparam sel_t PRB_INSTR      = 4'd2;
  localparam sel_t PRB_BRANCH     = 4'd3;
  localparam sel_t PRB_REGWRITE   = 4'd4;
  localparam sel_t PRB_REGDST     = 4'd5;
  localparam sel_t PRB_ALUSRC     = 4'd6;
  localparam sel_t PRB_ALUOP      = 4'd7;
  localparam sel_t PRB_REG_OUT1   = 4'd8;
  localparam sel_t PRB_ALU_SRC_B  = 4'd9;
  localparam sel_t PRB_ALU_CTRL   = 4'd10;
  localparam sel_t PRB_IMM        = 4'd11;
  localparam sel_t PRB_PC_NEXT    = 4'd12;
  localparam sel_t PRB_PC_BRANCH  = 4'd13;

endpackage

// File: rtl/debug_probe_viewer_input_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one raw input.
// level_d exposes the next stable value so a consumer can act on the same edge.
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_in,
  output logic level,
  output logic level_d,
  output logic fall,
  output logic rise
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             fall_q, fall_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample matching the stable level restarts the count, so bounces are rejected.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    fall_d   = 1'b0;
    rise_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        fall_d   = ~sync2_q;
        rise_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= RESET_LEVEL;
      sync2_q  <= RESET_LEVEL;
      stable_q <= RESET_LEVEL;
      cnt_q    <= '0;
      fall_q   <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= raw_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      fall_q   <= fall_d;
      rise_q   <= rise_d;
    end
  end

  assign level   = stable_q;
  assign level_d = stable_d;
  assign fall    = fall_q;
  assign rise    = rise_q;

endmodule

// File: rtl/debug_probe_viewer.sv
// Steps a probe index with two debounced buttons and presents the selected
// 32-bit probe word, either live or from a snapshot frozen by a slide switch.
module debug_probe_viewer
  import debug_probe_pkg::*;
#(
  parameter int NUM_PROBES      = NUM_PROBES_DEF,
  parameter int PROBE_W         = 32,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic                          key_next_n,
  input  logic                          key_prev_n,
  input  logic                          freeze,
  input  logic [NUM_PROBES*PROBE_W-1:0] probe_bus,
  output logic [SEL_W-1:0]              sel,
  output logic [PROBE_W-1:0]            disp_word,
  output logic                          sel_changed,
  output logic                          frozen
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_PROBES - 1);

  logic next_level, next_level_d, next_fall, next_rise;
  logic prev_level, prev_level_d, prev_fall, prev_rise;
  logic frz_level, frz_level_d, frz_fall, frz_rise;

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_key_next (
    .clk(CLOCK_50), .reset_n(reset_n), .raw_in(key_next_n),
    .level(next_level), .level_d(next_level_d), .fall(next_fall), .rise(next_rise)
  );

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_key_prev (
    .clk(CLOCK_50), .reset_n(reset_n), .raw_in(key_prev_n),
    .level(prev_level), .level_d(prev_level_d), .fall(prev_fall), .rise(prev_rise)
  );

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_freeze (
    .clk(CLOCK_50), .reset_n(reset_n), .raw_in(freeze),
    .level(frz_level), .level_d(frz_level_d), .fall(frz_fall), .rise(frz_rise)
  );

  logic unused_dbg;
  assign unused_dbg = ^{next_level, next_level_d, next_rise, prev_level, prev_level_d,
                        prev_rise, frz_fall, frz_rise};

  logic [SEL_W-1:0]              sel_q, sel_d;
  logic                          sel_upd_q, sel_upd_d;
  logic                          sel_changed_q, sel_changed_d;
  logic [PROBE_W-1:0]            disp_word_q, disp_word_d;
  logic [NUM_PROBES*PROBE_W-1:0] snap_q, snap_d;
  logic [PROBE_W-1:0]            live_word, snap_word;

  always_comb begin
    live_word = '0;
    snap_word = '0;
    for (int i = 0; i < NUM_PROBES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        live_word = probe_bus[i*PROBE_W +: PROBE_W];
        snap_word = snap_q[i*PROBE_W +: PROBE_W];
      end
    end
  end

  // Simultaneous next/prev events cancel: no move and no change pulse.
  always_comb begin
    sel_d     = sel_q;
    sel_upd_d = 1'b0;
    if (next_fall && !prev_fall) begin
      sel_d     = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
      sel_upd_d = 1'b1;
    end else if (prev_fall && !next_fall) begin
      sel_d     = (sel_q == '0) ? SEL_LAST : sel_q - SEL_W'(1);
      sel_upd_d = 1'b1;
    end
    sel_changed_d = sel_upd_q;
    // Capture on the edge where the freeze level becomes 1, so the first frozen word is valid.
    snap_d        = (frz_level_d && !frz_level) ? probe_bus : snap_q;
    disp_word_d   = frz_level ? snap_word : live_word;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      sel_q         <= '0;
      sel_upd_q     <= 1'b0;
      sel_changed_q <= 1'b0;
      disp_word_q   <= '0;
      snap_q        <= '0;
    end else begin
      sel_q         <= sel_d;
      sel_upd_q     <= sel_upd_d;
      sel_changed_q <= sel_changed_d;
      disp_word_q   <= disp_word_d;
      snap_q        <= snap_d;
    end
  end

  assign sel         = sel_q;
  assign disp_word   = disp_word_q;
  assign sel_changed = sel_changed_q;
  assign frozen      = frz_level;

endmodule
